// File: rtl/bcd_ctrl_pkg.sv
// Shared types and helpers for the digit-serial BCD adder sequencer.
`timescale 1ns/1ps
package bcd_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int             DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  // True for the decimal digit codes 0..9.
  function automatic logic is_bcd_digit(input logic [DIGIT_W-1:0] d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_settle_timer.sv
// Loadable down-counter that paces the external digit adder's settle time.
`timescale 1ns/1ps
module bcd_settle_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic         i_en,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // Load wins over enable; the count parks at zero rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial sequencer around one shared combinational BCD digit adder.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | ready for an operand pair; dp_* hold their last values
// DRIVE | present digit pair idx and ripple carry, arm settle timer
// WAIT  | adder settling; capture T/r when the timer reaches zero
// DONE  | result presented until the consumer takes it
`timescale 1ns/1ps
module bcd_serial_add_ctrl
  import bcd_ctrl_pkg::*;
#(
  parameter int DIGITS        = 3,
  parameter int SETTLE_CYCLES = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4*DIGITS-1:0]     in_a,
  input  logic [4*DIGITS-1:0]     in_b,
  input  logic                    in_cin,
  output logic [3:0]              dp_d,
  output logic [3:0]              dp_e,
  output logic                    dp_c,
  input  logic [3:0]              dp_t,
  input  logic                    dp_r,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4*DIGITS-1:0]     out_sum,
  output logic                    out_cout,
  output logic                    out_err,
  output logic                    busy
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_t                 r_state;
  logic [4*DIGITS-1:0]    r_a;
  logic [4*DIGITS-1:0]    r_b;
  logic [IDX_W-1:0]       r_idx;
  logic                   r_carry;
  logic [3:0]             r_dp_d;
  logic [3:0]             r_dp_e;
  logic                   r_dp_c;
  logic [4*DIGITS-1:0]    r_sum;
  logic                   r_cout;
  logic                   r_err;
  logic                   r_out_valid;

  logic                   w_err;
  logic                   w_tmr_zero;
  logic                   w_last;

  // Any non-decimal digit in either operand poisons the whole result.
  always_comb begin
    w_err = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!is_bcd_digit(in_a[i*DIGIT_W +: DIGIT_W]) ||
          !is_bcd_digit(in_b[i*DIGIT_W +: DIGIT_W])) begin
        w_err = 1'b1;
      end
    end
  end

  assign w_last = (r_idx == IDX_W'(DIGITS - 1));

  bcd_settle_timer #(.W(CNT_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (r_state == DRIVE),
    .i_en       (r_state == WAIT),
    .i_load_val (CNT_W'(SETTLE_CYCLES - 1)),
    .o_zero     (w_tmr_zero)
  );

  // Sequencer: one digit pair per DRIVE/WAIT round, LSD first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_dp_d      <= '0;
      r_dp_e      <= '0;
      r_dp_c      <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= in_a;
            r_b     <= in_b;
            r_carry <= in_cin;
            r_idx   <= '0;
            if (w_err) begin
              r_sum       <= '0;
              r_cout      <= 1'b0;
              r_err       <= 1'b1;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_err   <= 1'b0;
              r_state <= DRIVE;
            end
          end
        end
        DRIVE: begin
          r_dp_d  <= r_a[int'(r_idx)*DIGIT_W +: DIGIT_W];
          r_dp_e  <= r_b[int'(r_idx)*DIGIT_W +: DIGIT_W];
          r_dp_c  <= r_carry;
          r_state <= WAIT;
        end
        WAIT: begin
          if (w_tmr_zero) begin
            r_sum[int'(r_idx)*DIGIT_W +: DIGIT_W] <= dp_t;
            r_carry <= dp_r;
            if (w_last) begin
              r_cout      <= dp_r;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= DRIVE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign out_valid = r_out_valid;
  assign out_sum   = r_sum;
  assign out_cout  = r_cout;
  assign out_err   = r_err;
  assign dp_d      = r_dp_d;
  assign dp_e      = r_dp_e;
  assign dp_c      = r_dp_c;

endmodule

// File: doc/bcd_serial_add_ctrl.md
Name: bcd_serial_add_ctrl

Overview:
- Digit-serial sequencer for one shared, purely combinational BCD digit adder (D, E, c in; T, r out; worst-case settle about 405 ns).
- Accepts two multi-digit BCD operands over a valid/ready handshake.
- Feeds the digit adder one digit pair per step, least-significant first, waits a programmable settle time, then captures T and ripples r into the next step.
- Returns the packed BCD sum and final carry over an output valid/ready handshake. Replaces the area cost of a full parallel multi-digit BCD adder.

Parameters:
- DIGITS, 3, number of BCD digits per operand (must be >= 1).
- SETTLE_CYCLES, 5, clock cycles the digit adder is given to settle (must be >= 1; 5 at a 100 ns clock gives 500 ns > 405 ns).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  controller can accept operands.
- in_a  in  4*DIGITS  operand A, packed BCD, digit 0 in [3:0].
- in_b  in  4*DIGITS  operand B, packed BCD.
- in_cin  in  1  carry-in to digit 0.
- dp_d  out  4  digit of A driven to the digit adder (registered).
- dp_e  out  4  digit of B driven to the digit adder (registered).
- dp_c  out  1  carry driven to the digit adder (registered).
- dp_t  in  4  digit-adder sum digit.
- dp_r  in  1  digit-adder carry-out.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_sum  out  4*DIGITS  packed BCD sum.
- out_cout  out  1  final decimal carry.
- out_err  out  1  an input digit was > 9; sum is invalid.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - State is IDLE.
  - in_ready=1, out_valid=0, busy=0.
  - out_sum, out_cout, out_err, dp_d, dp_e, dp_c are all 0.
  - Digit index = 0, settle counter = 0.
  - Reset asserted mid-operation aborts the operation immediately; no partial result is emitted.
- States: IDLE, DRIVE, WAIT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: latch in_a, in_b, in_cin; idx=0; carry=in_cin.
  - Error check: err = OR over all 2*DIGITS input digits of (digit > 9).
  - If err: out_sum=0, out_cout=0, out_err=1, go to DONE (out_valid on the next cycle).
  - Otherwise: out_err=0, go to DRIVE.
- DRIVE (1 cycle):
  - Register dp_d=A[idx], dp_e=B[idx], dp_c=carry.
  - Load settle counter = SETTLE_CYCLES-1.
  - Go to WAIT.
- WAIT:
  - dp_* are held stable. The counter decrements each cycle.
  - In the cycle the counter is 0: out_sum[idx] <= dp_t, carry <= dp_r.
  - If idx == DIGITS-1: out_cout <= dp_r, go to DONE.
  - Otherwise: idx++, go to DRIVE.
- DONE:
  - out_valid=1, in_ready=0.
  - out_sum, out_cout and out_err are held stable while out_ready=0.
  - On out_ready=1: out_valid deasserts next cycle, go to IDLE.
  - Transactions do not overlap; a new accept needs IDLE.
- Latency, accept edge to out_valid high: DIGITS*(1+SETTLE_CYCLES) cycles (18 with defaults), or 1 cycle on error.
- Throughput: at most one operation per DIGITS*(1+SETTLE_CYCLES)+2 cycles.
- in_a, in_b and in_cin are ignored outside the accept cycle.
- dp_* outputs keep their last values in IDLE and DONE.
- A digit value of 9 is valid.
- The digit adder is trusted for valid BCD inputs; the controller does no correction itself.
- in_valid may drop without acceptance; no state change results.

Decomposition:
- Package bcd_ctrl_pkg:
  - state enum (IDLE, DRIVE, WAIT, DONE);
  - DIGIT_W=4;
  - BCD_MAX=4'd9;
  - function is_bcd_digit(4-bit) returning 1 for 0..9.
- One sub-module, bcd_settle_timer: loadable down-counter of width clog2(SETTLE_CYCLES) with load, enable and a zero flag.
- The bench instantiates the codebase's existing delayed BCD digit adder as the datapath, with a 100 ns clock.

Test Plan:
- Basic add, with respect to the accept edge:
  - Stimulus: A=002, B=774, cin=0.
  - Response: out_sum=776, out_cout=0, out_err=0; out_valid rises exactly 18 cycles after accept.
  - dp_d/dp_e show 2/4, then 0/7, then 0/7, each held 6 cycles.
- Full ripple:
  - 999+001, cin=0 -> out_sum=000, out_cout=1.
  - 999+999, cin=1 -> out_sum=999, out_cout=1.
  - 500+500, cin=0 -> out_sum=000, out_cout=1.
- Invalid digit:
  - Stimulus: A=0A2 (digit 1 = 4'hA), B=001.
  - Response: out_valid 1 cycle after accept, out_err=1, out_sum=000, out_cout=0; dp_* unchanged from the previous operation.
- Backpressure:
  - Stimulus: out_ready=0 for 10 cycles in DONE, with in_valid=1 and new operands pending.
  - Response: out_sum is stable and in_ready=0 throughout; one cycle after out_ready=1, out_valid=0 and in_ready=1; the pending operands are accepted next.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 asynchronously during WAIT of digit 1.
  - Response: all outputs are at reset values before the next clk edge, and no out_valid pulse follows.
  - Then run 123+456 with cin=1 -> out_sum=580, out_cout=0.
- Exhaustive single-digit check:
  - Stimulus: DIGITS=1, SETTLE_CYCLES=5, all D,E in 0..9 and cin in 0..1.
  - Response: every result matches the golden decimal sum; latency is 6 cycles each.
